// File: rtl/dmem_responder_if.sv
// Load/store port bundle between the memory stage (master) and the data memory (slave).
// Latency: none, wires only.
// Backpressure: the slave holds off new requests with gnt_o; the master keeps req_i up until granted.
// Ports: req_i/we_i/addr_i/wdata_i/be_i carry the request; gnt_o/rvalid_o/rdata_o/err_o carry the grant and response.
interface dmem_responder_if;
    logic        req_i;
    logic        we_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic [3:0]  be_i;
    logic        gnt_o;
    logic        rvalid_o;
    logic [31:0] rdata_o;
    logic        err_o;

    modport master (
        output req_i, we_i, addr_i, wdata_i, be_i,
        input  gnt_o, rvalid_o, rdata_o, err_o
    );

    modport slave (
        input  req_i, we_i, addr_i, wdata_i, be_i,
        output gnt_o, rvalid_o, rdata_o, err_o
    );
endinterface

// File: rtl/dmem_responder.sv
// Word-organised data RAM answering req/gnt/rvalid requests, with byte-enabled writes and range checking.
// Latency: accept edge to the rvalid_o cycle is WAIT_CYCLES edges; rvalid_o lasts one cycle.
// Backpressure: gnt_o drops while wait states run; a request held on the response cycle is accepted back-to-back.
// Ports: clk, rst (async, active-low), bus (slave side of dmem_responder_if).
module dmem_responder #(
    parameter int ADDR_W      = 10,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    dmem_responder_if.slave   bus
);
    localparam int         DEPTH     = 1 << ADDR_W;
    localparam bit         HAS_WAIT  = (WAIT_CYCLES > 0);
    localparam logic [2:0] WAIT_LOAD = HAS_WAIT ? 3'(WAIT_CYCLES - 1) : 3'd0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t             state, state_nxt;
    logic [2:0]         cnt, cnt_nxt;

    logic               lat_we;
    logic               lat_oor;
    logic [ADDR_W-1:0]  lat_idx;
    logic [31:0]        lat_wdata;
    logic [3:0]         lat_be;

    logic [31:0]        mem [DEPTH];
    logic [31:0]        mem_rd;
    logic               accept;
    logic               out_of_range;
    logic               commit;
    logic               in_resp;
    logic               unused_addr_lsb;

    // Byte offset within the word plays no part in word addressing.
    assign unused_addr_lsb = ^bus.addr_i[1:0];

    // Anything above the word-index field must be zero to hit the array.
    assign out_of_range = (bus.addr_i >> (ADDR_W + 2)) != 32'd0;

    // Grant is held low during reset so nothing can be accepted while the block is cleared.
    assign bus.gnt_o = rst && (state != ST_WAIT);
    assign accept    = bus.req_i && bus.gnt_o;
    assign in_resp   = (state == ST_RESP);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        unique case (state)
            ST_IDLE, ST_RESP: begin
                if (accept) begin
                    if (HAS_WAIT) begin
                        state_nxt = ST_WAIT;
                        cnt_nxt   = WAIT_LOAD;
                    end else begin
                        state_nxt = ST_RESP;
                    end
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt == 3'd0) begin
                    state_nxt = ST_RESP;
                end else begin
                    cnt_nxt = cnt - 3'd1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            cnt       <= 3'd0;
            lat_we    <= 1'b0;
            lat_oor   <= 1'b0;
            lat_idx   <= '0;
            lat_wdata <= 32'd0;
            lat_be    <= 4'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (accept) begin
                lat_we    <= bus.we_i;
                lat_oor   <= out_of_range;
                lat_idx   <= bus.addr_i[ADDR_W+1:2];
                lat_wdata <= bus.wdata_i;
                lat_be    <= bus.be_i;
            end
        end
    end

    // The write lands on the edge that ends the response cycle, so the response
    // itself still shows the old word and a read accepted on that edge sees the new one.
    // An asynchronous reset forces IDLE first, which drops any pending write.
    assign commit = in_resp && lat_we && !lat_oor;

    // Array is deliberately outside the reset domain.
    always_ff @(posedge clk) begin
        if (commit) begin
            for (int k = 0; k < 4; k++) begin
                if (lat_be[k]) begin
                    mem[lat_idx][8*k +: 8] <= lat_wdata[8*k +: 8];
                end
            end
        end
    end

    assign mem_rd       = mem[lat_idx];
    assign bus.rvalid_o = in_resp;
    assign bus.rdata_o  = (in_resp && !lat_oor) ? mem_rd : 32'd0;
    assign bus.err_o    = in_resp && lat_oor;
endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances (WAIT_CYCLES 2, 0, 3) behind one stimulus port selected by sel.
// Responses are checked against a word/byte-level memory model with per-byte "known" tracking.
// Summary: [TB] <tests> tests run, <failed> failed
module tb_dmem_responder;
    localparam int          DEPTH     = 1024;
    localparam logic [31:0] RANGE_LIM = 32'(4 * DEPTH);

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    int          sel = 0;
    int          cyc = 0;

    logic        req = 1'b0, we = 1'b0;
    logic [31:0] addr = 32'd0, wdata = 32'd0;
    logic [3:0]  be = 4'd0;
    logic        gnt, rvalid, err;
    logic [31:0] rdata;

    int          ntests = 0;
    int          nfail  = 0;
    logic [31:0] last_rdata;
    logic        last_err;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dmem_responder_if bus0();
    dmem_responder_if bus1();
    dmem_responder_if bus2();

    assign bus0.req_i = (sel == 0) && req;
    assign bus1.req_i = (sel == 1) && req;
    assign bus2.req_i = (sel == 2) && req;
    assign bus0.we_i = we;       assign bus1.we_i = we;       assign bus2.we_i = we;
    assign bus0.addr_i = addr;   assign bus1.addr_i = addr;   assign bus2.addr_i = addr;
    assign bus0.wdata_i = wdata; assign bus1.wdata_i = wdata; assign bus2.wdata_i = wdata;
    assign bus0.be_i = be;       assign bus1.be_i = be;       assign bus2.be_i = be;

    dmem_responder #(.ADDR_W(10), .WAIT_CYCLES(2)) u_dut0 (.clk(clk), .rst(rst), .bus(bus0));
    dmem_responder #(.ADDR_W(10), .WAIT_CYCLES(0)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));
    dmem_responder #(.ADDR_W(10), .WAIT_CYCLES(3)) u_dut2 (.clk(clk), .rst(rst), .bus(bus2));

    always_comb begin
        gnt = bus2.gnt_o; rvalid = bus2.rvalid_o; rdata = bus2.rdata_o; err = bus2.err_o;
        if (sel == 0) begin
            gnt = bus0.gnt_o; rvalid = bus0.rvalid_o; rdata = bus0.rdata_o; err = bus0.err_o;
        end else if (sel == 1) begin
            gnt = bus1.gnt_o; rvalid = bus1.rvalid_o; rdata = bus1.rdata_o; err = bus1.err_o;
        end
    end

    typedef struct {
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        int          gap;
    } req_t;

    typedef struct {
        req_t r;
        int   acc;
    } out_t;

    req_t pend[$];
    out_t outq[$];

    logic [31:0] mm [3][DEPTH];
    logic [3:0]  kn [3][DEPTH];

    function automatic int wc();
        case (sel)
            0:       return 2;
            1:       return 0;
            default: return 3;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s (sel %0d): observed %h expected %h", tag, sel, obs, exp);
        end
    endtask

    function automatic req_t mk(input bit w, input logic [31:0] a, input logic [31:0] d,
                                input logic [3:0] b, input int g);
        req_t r;
        r.we = w; r.addr = a; r.wdata = d; r.be = b; r.gap = g;
        return r;
    endfunction

    // Expected response for r, then apply its effect to the model.
    task automatic model_resp(input req_t r, output logic [31:0] er, output logic [31:0] mask,
                              output logic ee);
        int i;
        i = int'((r.addr / 32'd4) % 32'(DEPTH));
        if (r.addr >= RANGE_LIM) begin
            er = 32'd0; ee = 1'b1; mask = 32'hFFFF_FFFF;
        end else begin
            er = mm[sel][i]; ee = 1'b0;
            for (int k = 0; k < 4; k++) mask[8*k +: 8] = kn[sel][i][k] ? 8'hFF : 8'h00;
            if (r.we) begin
                for (int k = 0; k < 4; k++) begin
                    if (r.be[k]) begin
                        mm[sel][i][8*k +: 8] = r.wdata[8*k +: 8];
                        kn[sel][i][k] = 1'b1;
                    end
                end
            end
        end
    endtask

    // Called once per cycle, 1 time unit after the rising edge.
    task automatic observe();
        logic [31:0] er, mask;
        logic        ee;
        logic        exp_gnt;
        exp_gnt = 1'b1;
        if (outq.size() != 0 && (cyc - outq[0].acc) < wc()) exp_gnt = 1'b0;
        chk("gnt", 32'(gnt), 32'(exp_gnt));
        if (outq.size() != 0 && (cyc - outq[0].acc) > wc()) begin
            chk("rvalid_overdue", 32'(cyc - outq[0].acc), 32'(wc()));
            void'(outq.pop_front());
        end
        if (rvalid) begin
            chk("rvalid_expected", 32'(outq.size() != 0), 32'd1);
            if (outq.size() != 0) begin
                chk("latency", 32'(cyc - outq[0].acc), 32'(wc()));
                model_resp(outq[0].r, er, mask, ee);
                chk("rdata", rdata & mask, er & mask);
                chk("err", 32'(err), 32'(ee));
                void'(outq.pop_front());
            end
            last_rdata = rdata;
            last_err   = err;
        end else begin
            chk("idle_rdata", rdata, 32'd0);
            chk("idle_err", 32'(err), 32'd0);
        end
    endtask

    // Plays out pend[] on the selected instance until every request has responded.
    task automatic run();
        int  budget;
        int  gap_left;
        bit  will_acc;
        budget   = 0;
        gap_left = (pend.size() != 0) ? pend[0].gap : 0;
        while (budget < 500) begin
            observe();
            if (pend.size() == 0 && outq.size() == 0) break;
            if (pend.size() != 0 && gap_left == 0) begin
                req = 1'b1; we = pend[0].we; addr = pend[0].addr;
                wdata = pend[0].wdata; be = pend[0].be;
            end else begin
                req = 1'b0;
            end
            will_acc = req && gnt;
            @(posedge clk); #1;
            budget++;
            if (will_acc) begin
                outq.push_back('{r: pend[0], acc: cyc});
                void'(pend.pop_front());
                gap_left = (pend.size() != 0) ? pend[0].gap : 0;
            end else if (!req && gap_left > 0) begin
                gap_left--;
            end
        end
        chk("run_drained", 32'(pend.size() + outq.size()), 32'd0);
        pend.delete();
        outq.delete();
        req = 1'b0;
        @(posedge clk); #1;
    endtask

    function automatic req_t rand_req();
        logic [31:0] a;
        a = 32'($urandom_range(0, 15)) * 32'd4 + 32'($urandom_range(0, 3));
        if ($urandom_range(0, 7) == 0) a = a | (32'd1 << $urandom_range(12, 31));
        return mk(1'($urandom_range(0, 1)), a, $urandom(), 4'($urandom_range(0, 15)),
                  $urandom_range(0, 2));
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int s = 0; s < 3; s++)
            for (int i = 0; i < DEPTH; i++) begin mm[s][i] = 32'd0; kn[s][i] = 4'd0; end

        // Reset state on every instance.
        repeat (3) @(posedge clk);
        #1;
        for (int s = 0; s < 3; s++) begin
            sel = s; #1;
            chk("rst_gnt", 32'(gnt), 32'd0);
            chk("rst_rvalid", 32'(rvalid), 32'd0);
            chk("rst_rdata", rdata, 32'd0);
            chk("rst_err", 32'(err), 32'd0);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        for (int s = 0; s < 3; s++) begin
            sel = s; #1;
            chk("post_rst_gnt", 32'(gnt), 32'd1);
        end
        sel = 0;
        @(posedge clk); #1;

        // WAIT_CYCLES = 2: full write then read.
        pend.push_back(mk(1, 32'h10, 32'hDEADBEEF, 4'hF, 0));
        pend.push_back(mk(0, 32'h10, 32'h0, 4'h0, 1));
        run();
        chk("wc2_read", last_rdata, 32'hDEADBEEF);
        chk("wc2_read_err", 32'(last_err), 32'd0);

        // Byte enables: partial write returns old word, read sees merged word.
        pend.push_back(mk(1, 32'h10, 32'h11223344, 4'hF, 0));
        pend.push_back(mk(1, 32'h10, 32'hAABBCCDD, 4'b0101, 0));
        run();
        chk("be_write_resp", last_rdata, 32'h11223344);
        pend.push_back(mk(0, 32'h10, 32'h0, 4'h0, 0));
        run();
        chk("be_merged", last_rdata, 32'h11BB33DD);

        // WAIT_CYCLES = 0: back-to-back write then read of the same word.
        sel = 1; #1;
        pend.push_back(mk(1, 32'h20, 32'h1, 4'hF, 0));
        pend.push_back(mk(0, 32'h20, 32'h0, 4'h0, 0));
        run();
        chk("b2b_read", last_rdata, 32'h00000001);

        // Out of range write leaves word 0 alone.
        pend.push_back(mk(1, 32'h0, 32'h55AA55AA, 4'hF, 0));
        run();
        pend.push_back(mk(1, 32'h00001000, 32'h12345678, 4'hF, 0));
        run();
        chk("oor_err", 32'(last_err), 32'd1);
        chk("oor_rdata", last_rdata, 32'd0);
        pend.push_back(mk(0, 32'h0, 32'h0, 4'h0, 0));
        run();
        chk("oor_untouched", last_rdata, 32'h55AA55AA);

        // WAIT_CYCLES = 3: second request held through the wait states.
        sel = 2; #1;
        pend.push_back(mk(1, 32'h30, 32'h0F0F0F0F, 4'hF, 0));
        pend.push_back(mk(0, 32'h30, 32'h0, 4'h0, 0));
        run();
        chk("stall_read", last_rdata, 32'h0F0F0F0F);

        // Reset in the middle of a write's wait states.
        pend.push_back(mk(1, 32'h14, 32'hCAFEF00D, 4'hF, 0));
        run();
        chk("pre_rst_gnt", 32'(gnt), 32'd1);
        req = 1'b1; we = 1'b1; addr = 32'h14; wdata = 32'h0BADBAD0; be = 4'hF;
        @(posedge clk); #1;
        req = 1'b0;
        chk("mid_wait_gnt", 32'(gnt), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0; #1;
        chk("in_rst_gnt", 32'(gnt), 32'd0);
        for (int i = 0; i < 4; i++) begin
            chk("in_rst_rvalid", 32'(rvalid), 32'd0);
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rel_gnt", 32'(gnt), 32'd1);
        chk("rel_rvalid", 32'(rvalid), 32'd0);
        @(posedge clk); #1;
        pend.push_back(mk(0, 32'h14, 32'h0, 4'h0, 0));
        run();
        chk("rst_no_write", last_rdata, 32'hCAFEF00D);

        // Randomised traffic on every instance.
        for (int s = 0; s < 3; s++) begin
            sel = s; #1;
            for (int n = 0; n < 30; n++) pend.push_back(rand_req());
            run();
        end

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end
endmodule
